// File: rtl/fifo_pkg.sv
// Shared helpers for the show-ahead FIFO: pointer sizing and level/threshold compares.
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic logic level_ge(input int unsigned level, input int unsigned thresh);
        return level >= thresh;
    endfunction

    function automatic logic level_le(input int unsigned level, input int unsigned thresh);
        return level <= thresh;
    endfunction

endpackage

// File: rtl/fifo_reg_ram.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_reg_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 21,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [ADDR_WIDTH-1:0] RADDR,
    output logic [DATA_WIDTH-1:0] RDATA
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    // Storage is deliberately not reset; validity is tracked by the pointers.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem_q[WADDR] <= WDATA;
        end
    end

    assign RDATA = mem_q[RADDR];

endmodule

// File: rtl/fifo_sync_pw.sv
// Single-clock show-ahead FIFO with fill level, almost-full/empty and synchronous flush.
// Optional sticky OVF/UDF error flags with ERR_CLR are built when FIFO_ERRFLAG_EN is defined.
module fifo_sync_pw
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 21,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_MARGIN  = 1,
    parameter int unsigned AE_MARGIN  = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLR,
    input  logic                  WREN,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic                  FULL,
    output logic                  AFULL,
    input  logic                  RDEN,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  EMPTY,
    output logic                  AEMPTY,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  OVF,
    output logic                  UDF,
    input  logic                  ERR_CLR
);

    localparam int unsigned PTR_W     = ptr_width(ADDR_WIDTH);
    localparam int unsigned DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam int unsigned AF_THRESH = DEPTH - AF_MARGIN;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             empty, full;
    logic [PTR_W-1:0] level;
    logic             wr_acc, rd_acc;

    // Flags are pure decodes of the pointers, so they follow the registers with no extra lag.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    assign level = wptr_q - rptr_q;

    // A write into a full FIFO is still taken when a pop frees the head slot this cycle.
    assign wr_acc = WREN & (~full | RDEN) & ~CLR;
    assign rd_acc = RDEN & ~empty & ~CLR;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (CLR) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_reg_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .CLK  (CLK),
        .WE   (wr_acc),
        .WADDR(wptr_q[ADDR_WIDTH-1:0]),
        .WDATA(WDATA),
        .RADDR(rptr_q[ADDR_WIDTH-1:0]),
        .RDATA(RDATA)
    );

    assign EMPTY  = empty;
    assign FULL   = full;
    assign LEVEL  = level;
    assign AFULL  = level_ge(32'(level), AF_THRESH);
    assign AEMPTY = level_le(32'(level), AE_MARGIN);

`ifdef FIFO_ERRFLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
    logic ovf_set, udf_set;

    // A flush cycle neither raises nor clears the error flags.
    assign ovf_set = ~CLR & WREN & full & ~RDEN;
    assign udf_set = ~CLR & RDEN & empty;

    // A fresh error wins over a simultaneous ERR_CLR.
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~ERR_CLR);
        udf_d = udf_set | (udf_q & ~ERR_CLR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = ERR_CLR;
    assign OVF = 1'b0;
    assign UDF = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_pw.sv
// Directed scoreboard bench for fifo_sync_pw; expected error flags follow FIFO_ERRFLAG_EN.
module tb_fifo_sync_pw;

    localparam int unsigned DW    = 21;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          CLR, WREN, RDEN, ERR_CLR;
    logic [DW-1:0] WDATA;
    logic [DW-1:0] RDATA;
    logic          FULL, AFULL, EMPTY, AEMPTY, OVF, UDF;
    logic [AW:0]   LEVEL;

    logic [DW-1:0] q [$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    int            n_total = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;

    always #5 CLK = ~CLK;

    fifo_sync_pw #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_MARGIN (1),
        .AE_MARGIN (1)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .CLR    (CLR),
        .WREN   (WREN),
        .WDATA  (WDATA),
        .FULL   (FULL),
        .AFULL  (AFULL),
        .RDEN   (RDEN),
        .RDATA  (RDATA),
        .EMPTY  (EMPTY),
        .AEMPTY (AEMPTY),
        .LEVEL  (LEVEL),
        .OVF    (OVF),
        .UDF    (UDF),
        .ERR_CLR(ERR_CLR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        int unsigned n;
        n = q.size();
        check({tag, "/level"},  32'(LEVEL),  n);
        check({tag, "/empty"},  32'(EMPTY),  32'(n == 0));
        check({tag, "/full"},   32'(FULL),   32'(n == DEPTH));
        check({tag, "/afull"},  32'(AFULL),  32'(n >= DEPTH - 1));
        check({tag, "/aempty"}, 32'(AEMPTY), 32'(n <= 1));
        check({tag, "/ovf"},    32'(OVF),    32'(m_ovf));
        check({tag, "/udf"},    32'(UDF),    32'(m_udf));
    endtask

    // One clock cycle of stimulus; head data checked before the edge, flags after it.
    task automatic step(input string tag, input logic wr, input logic [DW-1:0] wd,
                        input logic rd, input logic cl, input logic ec);
        logic full_m, empty_m;
        WREN = wr; WDATA = wd; RDEN = rd; CLR = cl; ERR_CLR = ec;
        #1;
        if (rd && q.size() != 0) check({tag, "/rdata"}, 32'(RDATA), 32'(q[0]));
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() == 0);
        @(posedge CLK);
        #1;
        if (cl) begin
            q.delete();
        end else begin
            if (rd && !empty_m) void'(q.pop_front());
            if (wr && (!full_m || rd)) q.push_back(wd);
        end
`ifdef FIFO_ERRFLAG_EN
        m_ovf = (!cl && wr && full_m && !rd) || (m_ovf && !ec);
        m_udf = (!cl && rd && empty_m) || (m_udf && !ec);
`endif
        WREN = 1'b0; RDEN = 1'b0; CLR = 1'b0; ERR_CLR = 1'b0;
        check_flags(tag);
    endtask

    initial begin
        RST_N = 1'b0; CLR = 1'b0; WREN = 1'b0; RDEN = 1'b0; ERR_CLR = 1'b0; WDATA = '0;
        #12;
        check_flags("reset");
        RST_N = 1'b1;

        // 1: fill to full, then drain in order
        for (int i = 1; i <= 8; i++) step("t1_wr", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  step("t1_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 2: overflow write is dropped
        for (int i = 1; i <= 8; i++) step("t2_wr", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        step("t2_ovf", 1'b1, 21'h1FFFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  step("t2_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 3: simultaneous read/write while full, pointers wrapping
        for (int i = 1; i <= 8; i++) step("t3_fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("t3_rw", 1'b1, DW'(32'h100 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  step("t3_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 4: underflow, then write+read on empty
        step("t4_udf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("t4_wrrd", 1'b1, 21'hABCDE, 1'b1, 1'b0, 1'b0);
        check("t4_head", 32'(RDATA), 32'h000ABCDE);
        step("t4_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // 5: flush overrides write, error clear, async reset mid-burst
        for (int i = 1; i <= 5; i++) step("t5_wr", 1'b1, DW'(32'h40 + i), 1'b0, 1'b0, 1'b0);
        step("t5_clr", 1'b1, 21'h777, 1'b0, 1'b1, 1'b0);
        step("t5_errclr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) step("t5_burst", 1'b1, DW'(32'h60 + i), 1'b0, 1'b0, 1'b0);
        WREN = 1'b1; WDATA = 21'h99;
        RST_N = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_flags("t5_rst");
        #2;
        WREN = 1'b0;
        RST_N = 1'b1;
        step("t5_post", 1'b1, 21'h55, 1'b0, 1'b0, 1'b0);
        check("t5_post_head", 32'(RDATA), 32'h55);
        step("t5_post_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
